// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spi_pkg;

  localparam int unsigned EDGE_W = 5;
  localparam int unsigned HALF_W = 7;

  localparam logic [HALF_W-1:0] HALF_DIV4   = 7'd2;
  localparam logic [HALF_W-1:0] HALF_DIV16  = 7'd8;
  localparam logic [HALF_W-1:0] HALF_DIV64  = 7'd32;
  localparam logic [HALF_W-1:0] HALF_DIV128 = 7'd64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  // Clock cycles per SCK half period for a divider select code.
  function automatic logic [HALF_W-1:0] half_of(input logic [1:0] spr);
    logic [HALF_W-1:0] h;
    case (spr)
      2'b00:   h = HALF_DIV4;
      2'b01:   h = HALF_DIV16;
      2'b10:   h = HALF_DIV64;
      default: h = HALF_DIV128;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period timer: one-cycle tick every HALF clocks while running.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] spr,
  input  logic       run,
  input  logic       clr,
  output logic       tick_c
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] last_c;

  // Count 0..HALF-1 and wrap; park at zero when idle or cleared.
  always_comb begin
    last_c = CNT_WIDTH'(half_of(spr) - HALF_W'(1));
    tick_c = run && !clr && (cnt_q == last_c);
    cnt_d  = cnt_q + CNT_WIDTH'(1);
    if (!run || clr || (cnt_q == last_c)) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: SCK/SS_n generation and shifter strobes.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spe,
  input  logic       mstr,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [1:0] spr,
  input  logic       spdr_wr,
  input  logic       spif_clr,
  output logic       sck,
  output logic       ss_n,
  output logic       sample_strb,
  output logic       shift_strb,
  output logic       shifter_en,
  output logic       spdr_load,
  output logic       spdr_capture,
  output logic       spif,
  output logic       wcol,
  output logic       busy
);

  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DWIDTH);

  state_e            state_q, state_d;
  logic              sck_q, sck_d;
  logic              ss_n_q, ss_n_d;
  logic              sample_strb_q, sample_strb_d;
  logic              shift_strb_q, shift_strb_d;
  logic              spdr_load_q, spdr_load_d;
  logic              spdr_capture_q, spdr_capture_d;
  logic              shifter_en_q, shifter_en_d;
  logic              spif_q, spif_d;
  logic              wcol_q, wcol_d;
  logic              busy_q, busy_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [1:0]        spr_q, spr_d;

  logic              tick_c;
  logic              abort_c;
  logic              run_c;
  logic [EDGE_W-1:0] edge_nx_c;

  assign run_c = (state_q != IDLE);

  spi_clk_div #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .spr    (spr_q),
    .run    (run_c),
    .clr    (abort_c),
    .tick_c (tick_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d        = state_q;
    sck_d          = sck_q;
    ss_n_d         = ss_n_q;
    sample_strb_d  = 1'b0;
    shift_strb_d   = 1'b0;
    spdr_load_d    = 1'b0;
    spdr_capture_d = 1'b0;
    edge_d         = edge_q;
    cpol_d         = cpol_q;
    cpha_d         = cpha_q;
    spr_d          = spr_q;
    abort_c        = 1'b0;
    edge_nx_c      = edge_q + EDGE_W'(1);

    case (state_q)
      IDLE: begin
        sck_d  = cpol;
        ss_n_d = 1'b1;
        edge_d = '0;
        if (spdr_wr && spe && mstr) begin
          state_d      = LOAD;
          cpol_d       = cpol;
          cpha_d       = cpha;
          spr_d        = spr;
          ss_n_d       = 1'b0;
          spdr_load_d  = 1'b1;
          // With cpha=0 the MSB must be on MOSI before the first edge.
          shift_strb_d = !cpha;
        end
      end
      LOAD: begin
        state_d = XFER;
      end
      XFER: begin
        if (tick_c) begin
          edge_d = edge_nx_c;
          sck_d  = !sck_q;
          if (edge_nx_c[0]) begin
            sample_strb_d = !cpha_q;
            shift_strb_d  = cpha_q;
          end else begin
            sample_strb_d = cpha_q;
            shift_strb_d  = !cpha_q && (edge_nx_c != LAST_EDGE);
          end
          if (edge_nx_c == LAST_EDGE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        sck_d = cpol_q;
        if (tick_c) begin
          spdr_capture_d = 1'b1;
          ss_n_d         = 1'b1;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Losing SPI enable mid-transfer drops straight back to idle.
    if ((state_q != IDLE) && !spe) begin
      abort_c        = 1'b1;
      state_d        = IDLE;
      sck_d          = cpol;
      ss_n_d         = 1'b1;
      sample_strb_d  = 1'b0;
      shift_strb_d   = 1'b0;
      spdr_capture_d = 1'b0;
      edge_d         = '0;
    end

    // Flags: a set in the same cycle as a clear wins.
    spif_d = spdr_capture_d || (spif_q && !spif_clr);
    wcol_d = (spdr_wr && (state_q != IDLE)) || (wcol_q && !spif_clr);

    busy_d       = (state_d != IDLE);
    shifter_en_d = busy_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      sck_q          <= 1'b0;
      ss_n_q         <= 1'b1;
      sample_strb_q  <= 1'b0;
      shift_strb_q   <= 1'b0;
      spdr_load_q    <= 1'b0;
      spdr_capture_q <= 1'b0;
      shifter_en_q   <= 1'b0;
      spif_q         <= 1'b0;
      wcol_q         <= 1'b0;
      busy_q         <= 1'b0;
      edge_q         <= '0;
      cpol_q         <= 1'b0;
      cpha_q         <= 1'b0;
      spr_q          <= 2'b00;
    end else begin
      state_q        <= state_d;
      sck_q          <= sck_d;
      ss_n_q         <= ss_n_d;
      sample_strb_q  <= sample_strb_d;
      shift_strb_q   <= shift_strb_d;
      spdr_load_q    <= spdr_load_d;
      spdr_capture_q <= spdr_capture_d;
      shifter_en_q   <= shifter_en_d;
      spif_q         <= spif_d;
      wcol_q         <= wcol_d;
      busy_q         <= busy_d;
      edge_q         <= edge_d;
      cpol_q         <= cpol_d;
      cpha_q         <= cpha_d;
      spr_q          <= spr_d;
    end
  end

  assign sck          = sck_q;
  assign ss_n         = ss_n_q;
  assign sample_strb  = sample_strb_q;
  assign shift_strb   = shift_strb_q;
  assign spdr_load    = spdr_load_q;
  assign spdr_capture = spdr_capture_q;
  assign shifter_en   = shifter_en_q;
  assign spif         = spif_q;
  assign wcol         = wcol_q;
  assign busy         = busy_q;

endmodule
